// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and count width.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Bits needed to hold a shift count in the range 0..w
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage : usr_pkg

// File: rtl/usr_bit_slice.sv
// One storage bit of the universal shift register: 4:1 mode mux into an enabled DFF
// with synchronous reset to a per-bit value.
module usr_bit_slice
    import usr_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic       d_i,
    input  logic       from_lower_i,   // lower neighbour (or serial-in) used on shift left
    input  logic       from_upper_i,   // upper neighbour (or serial-in) used on shift right
    output logic       q_o
);

    logic q_d;
    logic q_q;

    // Select the next bit value according to the operating mode
    always_comb begin
        q_d = q_q;
        case (mode_i)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = from_upper_i;
            MODE_SHL:  q_d = from_lower_i;
            MODE_LOAD: q_d = d_i;
            default:   q_d = q_q;
        endcase
    end

    // Storage flop: reset wins over enable
    always_ff @(posedge clk) begin
        if (rst_i) begin
            q_q <= RST_VAL;
        end else if (en_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : usr_bit_slice

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with
// serial ports at both ends and a saturating shift counter with drained flag.
// Optional macro USR_ROTATE_EN adds input rot, which wraps the exiting bit back in.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin_r,
    input  logic                       sin_l,
`ifdef USR_ROTATE_EN
    input  logic                       rot,
`endif
    output logic [WIDTH-1:0]           q,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [cnt_w(WIDTH)-1:0]    shift_cnt,
    output logic                       drained
);

    localparam int unsigned CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] q_w;
    logic             msb_in;
    logic             lsb_in;
    logic [CW-1:0]    shift_cnt_d;
    logic [CW-1:0]    shift_cnt_q;

    // Bits entering at each end: serial inputs, or the opposite end bit when rotating
`ifdef USR_ROTATE_EN
    always_comb begin
        msb_in = rot ? q_w[0]       : sin_r;
        lsb_in = rot ? q_w[WIDTH-1] : sin_l;
    end
`else
    always_comb begin
        msb_in = sin_r;
        lsb_in = sin_l;
    end
`endif

    // Storage bank, one slice per bit with neighbour wiring
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic from_lower;
        logic from_upper;

        if (i == 0) begin : g_lsb
            assign from_lower = lsb_in;
        end else begin : g_mid_lo
            assign from_lower = q_w[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign from_upper = msb_in;
        end else begin : g_mid_hi
            assign from_upper = q_w[i+1];
        end

        usr_bit_slice #(
            .RST_VAL (RESET_VAL[i])
        ) u_slice (
            .clk          (clk),
            .rst_i        (rst),
            .en_i         (en),
            .mode_i       (mode),
            .d_i          (d[i]),
            .from_lower_i (from_lower),
            .from_upper_i (from_upper),
            .q_o          (q_w[i])
        );
    end

    // Shift counter next state: count shifts up to WIDTH, clear on load
    always_comb begin
        shift_cnt_d = shift_cnt_q;
        case (mode)
            MODE_SHR, MODE_SHL: begin
                if (shift_cnt_q != CW'(WIDTH)) begin
                    shift_cnt_d = shift_cnt_q + CW'(1);
                end
            end
            MODE_LOAD: shift_cnt_d = '0;
            default:   shift_cnt_d = shift_cnt_q;
        endcase
    end

    // Shift counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt_q <= '0;
        end else if (en) begin
            shift_cnt_q <= shift_cnt_d;
        end
    end

    assign q         = q_w;
    assign sout_r    = q_w[0];
    assign sout_l    = q_w[WIDTH-1];
    assign shift_cnt = shift_cnt_q;
    assign drained   = (shift_cnt_q == CW'(WIDTH));

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8 and WIDTH=1 instances).
module tb_universal_shift_reg;

`ifdef USR_ROTATE_EN
    localparam bit HAS_ROT = 1'b1;
`else
    localparam bit HAS_ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic       rot = 1'b0;

    logic [7:0] q;
    logic       sout_r, sout_l, drained;
    logic [3:0] shift_cnt;

    logic [0:0] q1;
    logic       sout_r1, sout_l1, drained1;
    logic [0:0] shift_cnt1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_q;
    int         m_cnt;
    logic       m1_q;
    int         m1_cnt;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l),
`ifdef USR_ROTATE_EN
        .rot(rot),
`endif
        .q(q), .sout_r(sout_r), .sout_l(sout_l),
        .shift_cnt(shift_cnt), .drained(drained)
    );

    universal_shift_reg #(.WIDTH(1), .RESET_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d[0:0]),
        .sin_r(sin_r), .sin_l(sin_l),
`ifdef USR_ROTATE_EN
        .rot(rot),
`endif
        .q(q1), .sout_r(sout_r1), .sout_l(sout_l1),
        .shift_cnt(shift_cnt1), .drained(drained1)
    );

    // Apply one cycle of stimulus, advance the models, sample #1 after the edge
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] dv, input logic sr, input logic sl,
                        input logic rt);
        logic eff_rot;
        logic in_bit;
        eff_rot = HAS_ROT && rt;
        rst = r; en = e; mode = m; d = dv; sin_r = sr; sin_l = sl; rot = rt;
        if (r) begin
            m_q = 8'hA5; m_cnt = 0; m1_q = 1'b1; m1_cnt = 0;
        end else if (e) begin
            if (m == 2'd1) begin
                in_bit = eff_rot ? m_q[0] : sr;
                m_q = 8'((m_q >> 1) + (in_bit ? 128 : 0));
                m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
                m1_q = eff_rot ? m1_q : sr;
                m1_cnt = 1;
            end else if (m == 2'd2) begin
                in_bit = eff_rot ? m_q[7] : sl;
                m_q = 8'(((m_q * 2) % 256) + (in_bit ? 1 : 0));
                m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
                m1_q = eff_rot ? m1_q : sl;
                m1_cnt = 1;
            end else if (m == 2'd3) begin
                m_q = dv; m_cnt = 0; m1_q = dv[0]; m1_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got=%h exp=a5", q); end
        checks++; if (shift_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained got=%b exp=0", drained); end
        checks++; if (sout_r !== 1'b1 || sout_l !== 1'b1) begin errors++; $display("FAIL reset_sout got=%b%b exp=11", sout_l, sout_r); end
        checks++; if (q1 !== 1'b1 || shift_cnt1 !== 1'b0) begin errors++; $display("FAIL reset_w1 got q=%b cnt=%b exp q=1 cnt=0", q1, shift_cnt1); end
    endtask

    task automatic test_load_shift_right();
        logic [7:0] exp_seq;
        exp_seq = 8'b1011_0001;
        step(1'b0, 1'b1, 2'b11, 8'b1011_0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sout_r !== exp_seq[i]) begin errors++; $display("FAIL shr_sout_r[%0d] got=%b exp=%b", i, sout_r, exp_seq[i]); end
            step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL shr_q got=%h exp=00", q); end
        checks++; if (shift_cnt !== 4'd8 || drained !== 1'b1) begin errors++; $display("FAIL shr_drained got cnt=%0d dr=%b exp cnt=8 dr=1", shift_cnt, drained); end
        step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (shift_cnt !== 4'd8) begin errors++; $display("FAIL shr_saturate got=%0d exp=8", shift_cnt); end
    endtask

    task automatic test_deserialise();
        logic [7:0] bits;
        bits = 8'b1100_1010;
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, bits[i], 1'b0);
        end
        checks++; if (q !== 8'b1100_1010) begin errors++; $display("FAIL deser_q got=%h exp=ca", q); end
        checks++; if (drained !== 1'b1) begin errors++; $display("FAIL deser_drained got=%b exp=1", drained); end
        step(1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
        checks++; if (q !== 8'h3C || shift_cnt !== 4'd0 || drained !== 1'b0) begin
            errors++; $display("FAIL deser_load got q=%h cnt=%0d dr=%b exp q=3c cnt=0 dr=0", q, shift_cnt, drained);
        end
    endtask

    task automatic test_enable_hold();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b01, 8'hFF, 1'b1, 1'b1, 1'b0);
        checks++; if (q !== 8'h3C || shift_cnt !== 4'd0) begin errors++; $display("FAIL en_low got q=%h cnt=%0d exp q=3c cnt=0", q, shift_cnt); end
        step(1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0);
        checks++; if (q !== 8'h3C || shift_cnt !== 4'd0) begin errors++; $display("FAIL hold got q=%h cnt=%0d exp q=3c cnt=0", q, shift_cnt); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (shift_cnt !== 4'd3) begin errors++; $display("FAIL mid_cnt got=%0d exp=3", shift_cnt); end
        step(1'b1, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
        checks++; if (q !== 8'hA5 || shift_cnt !== 4'd0) begin errors++; $display("FAIL mid_reset got q=%h cnt=%0d exp q=a5 cnt=0", q, shift_cnt); end
    endtask

    task automatic test_rotate();
        step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL rot_left got=%h exp=03", q); end
        step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (q !== 8'h81 || shift_cnt !== 4'd2) begin errors++; $display("FAIL rot_right got q=%h cnt=%0d exp q=81 cnt=2", q, shift_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom));
            checks++;
            if (q !== m_q || shift_cnt !== 4'(m_cnt) || drained !== (m_cnt == 8) ||
                sout_r !== m_q[0] || sout_l !== m_q[7]) begin
                errors++;
                $display("FAIL rand_w8[%0d] got q=%h cnt=%0d dr=%b sr=%b sl=%b exp q=%h cnt=%0d", n,
                         q, shift_cnt, drained, sout_r, sout_l, m_q, m_cnt);
            end
            checks++;
            if (q1 !== m1_q || shift_cnt1 !== 1'(m1_cnt) || drained1 !== (m1_cnt == 1) ||
                sout_r1 !== m1_q || sout_l1 !== m1_q) begin
                errors++;
                $display("FAIL rand_w1[%0d] got q=%b cnt=%0d dr=%b exp q=%b cnt=%0d", n,
                         q1, shift_cnt1, drained1, m1_q, m1_cnt);
            end
        end
    endtask

    initial begin
        m_q = 8'hA5; m_cnt = 0; m1_q = 1'b1; m1_cnt = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_shift_right();
        test_deserialise();
        test_enable_hold();
        test_reset_mid();
        if (HAS_ROT) test_rotate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_universal_shift_reg
